ser_packer: RTL and testbench
=============================

Name: ser_packer

Overview:
- Parallel-to-serial transmitter for the CNN datapath.
- Accepts one parallel word per channel (NO_CH channels in lockstep) through a valid/ready handshake.
- Emits each word as a serial stream of SER_BW-bit chunks, least significant chunk first, in the format the serial-input layers (maxpool, serial convolutions) consume.
- Each word is sign-extended to a whole number of chunks; two consecutive emitted words form one maxpool compare pair.

Parameters:
- NO_CH, 10, number of parallel channels.
- BW_IN, 12, signed word width per channel.
- SER_BW, 4, chunk width per channel per cycle; any value >= 1.
- WORD_CYC (localparam), ceil(BW_IN/SER_BW), cycles per word.
- PAD_W (localparam), WORD_CYC*SER_BW, padded word width.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- vld_in  input  1  parallel word valid
- rdy_in  output  1  block can accept a word this cycle
- data_in  input  [NO_CH-1:0][BW_IN-1:0]  signed parallel words
- vld_out  output  1  data_out holds a valid chunk
- data_out  output  [NO_CH-1:0][SER_BW-1:0]  current chunk per channel
- last_out  output  1  data_out is the final (most significant) chunk of a word

Behaviour:
- Storage per channel:
  - shifter sh[PAD_W].
  - one-entry hold buffer hb[PAD_W] with flag hold_vld.
  - shared chunk counter cnt, width clog2(WORD_CYC), minimum 1 bit.
  - shared flag active.
- Padding: a word is stored as {sign-extension of bit BW_IN-1, word} to PAD_W bits at accept time.
- Handshake:
  - accept = vld_in & rdy_in.
  - rdy_in = ~hold_vld & ~rst.
  - data_in is ignored when accept=0.
- Outputs are direct from registers:
  - data_out[i] = sh[i][SER_BW-1:0].
  - vld_out = active.
  - last_out = active & (cnt == WORD_CYC-1).
- Shifter advance: when active and cnt < WORD_CYC-1, sh shifts right by SER_BW (fill 0) and cnt increments.
- Word end (active & cnt == WORD_CYC-1), cnt goes to 0. Priority for reloading sh:
  1. hold_vld: load sh from hb, clear hold_vld, active stays 1.
  2. else accept: load sh from data_in directly, active stays 1.
  3. else active goes to 0.
- Idle (active=0): accept loads sh directly, active goes to 1, cnt=0.
- Busy and not at word end: accept writes hb and sets hold_vld.
- At word end with hold_vld=1, rdy_in is 0, so no simultaneous accept.
- Latency: a word accepted at clock edge t drives chunk 0 on data_out in the cycle after t. Chunk k appears k cycles later.
- Throughput:
  - sustained one word per WORD_CYC cycles.
  - vld_out has no gaps while input is available.
  - rdy_in deasserts only while hold is full.
- WORD_CYC=1 (SER_BW >= BW_IN): each word is one chunk, last_out = vld_out, hold never fills under continuous input.
- No downstream backpressure exists; chunks are never stalled once emitted.
- Reset (including mid-word): active=0, cnt=0, hold_vld=0, sh=0, hb=0.
  - vld_out=0, last_out=0, data_out=0 from the next cycle.
  - rdy_in=0 while rst is high, 1 after.
  - In-flight and held words are discarded.
- Channels are fully independent in data, share all control.

Test Plan:
- NO_CH=2, BW_IN=12, SER_BW=4; single accept of ch0=0xABC, ch1=0x123 -> next 3 cycles data_out ch0 = C,B,A and ch1 = 3,2,1; vld_out=1,1,1; last_out=0,0,1; then vld_out=0.
- BW_IN=10, SER_BW=4; ch0=0x2A5 (negative) -> chunks 5,A,E (padded 0xEA5); ch0=0x0A5 -> 5,A,0.
- vld_in held high with W0,W1,W2,W3 -> accepts at cycles 0,1,4,7; vld_out continuous for 12 cycles; last_out every 3rd cycle; rdy_in low on cycles 2,3,5,6.
- BW_IN=8, SER_BW=16 -> WORD_CYC=1; continuous input 0x80,0x7F -> data_out 0xFF80 then 0x007F on consecutive cycles; last_out=vld_out; rdy_in never low.
- Assert rst on chunk 1 of a word with hold full -> next cycle vld_out=0, rdy_in=0; after release, new word emits cleanly from chunk 0; old held word is never emitted.
- Loopback: ser_packer driving maxpool (same params) with pairs (-5,3), (7,7), (-2048,-1) -> maxpool outputs 3, 7, -1.

Source files
------------

// File: rtl/ser_packer.sv
// Parallel-to-serial packer: one signed word per channel in, SER_BW-bit
// chunks out LSB first, with a one-word hold buffer for gapless streaming.
module ser_packer #(
  parameter int NO_CH  = 10,
  parameter int BW_IN  = 12,
  parameter int SER_BW = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           vld_in,
  output logic                           rdy_in,
  input  logic [NO_CH-1:0][BW_IN-1:0]    data_in,
  output logic                           vld_out,
  output logic [NO_CH-1:0][SER_BW-1:0]   data_out,
  output logic                           last_out
);

  localparam int WORD_CYC = (BW_IN + SER_BW - 1) / SER_BW;
  localparam int PAD_W    = WORD_CYC * SER_BW;
  localparam int CW       = (WORD_CYC > 1) ? $clog2(WORD_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WORD_CYC - 1);

  typedef logic [NO_CH-1:0][PAD_W-1:0] word_t;

  word_t         sh_q, sh_d;
  word_t         hb_q, hb_d;
  word_t         pad;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          active_q, active_d;
  logic          hold_q, hold_d;
  logic          accept, word_end, adv;

  assign accept   = vld_in & rdy_in;
  assign word_end = active_q & (cnt_q == CNT_LAST);
  assign adv      = active_q & ~word_end;

  always_comb begin
    for (int i = 0; i < NO_CH; i++)
      pad[i] = PAD_W'($signed(data_in[i]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q     <= '0;
      hb_q     <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      hold_q   <= 1'b0;
    end else begin
      sh_q     <= sh_d;
      hb_q     <= hb_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      hold_q   <= hold_d;
    end
  end

  always_comb begin
    sh_d     = sh_q;
    hb_d     = hb_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    hold_d   = hold_q;
    unique case (1'b1)
      word_end: begin
        cnt_d = '0;
        // a held word always wins; rdy_in is low then anyway
        if (hold_q) begin
          sh_d   = hb_q;
          hold_d = 1'b0;
        end else if (accept) begin
          sh_d = pad;
        end else begin
          active_d = 1'b0;
        end
      end
      adv: begin
        for (int i = 0; i < NO_CH; i++)
          sh_d[i] = sh_q[i] >> SER_BW;
        cnt_d = cnt_q + 1'b1;
        if (accept) begin
          hb_d   = pad;
          hold_d = 1'b1;
        end
      end
      default: begin
        if (accept) begin
          sh_d     = pad;
          active_d = 1'b1;
          cnt_d    = '0;
        end
      end
    endcase
  end

  always_comb begin
    rdy_in   = ~hold_q & ~rst;
    vld_out  = active_q;
    last_out = word_end;
    for (int i = 0; i < NO_CH; i++)
      data_out[i] = sh_q[i][SER_BW-1:0];
  end

endmodule

// File: tb/tb_ser_packer.sv
// Bench for ser_packer: schedule-based reference model on a 2-channel
// instance plus literal checks on narrow and single-chunk instances.
module tb_ser_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic vA, rA, vldA, lastA;
  logic [1:0][11:0] dA;
  logic [1:0][3:0]  qA;
  logic vB, rB, vldB, lastB;
  logic [0:0][9:0]  dB;
  logic [0:0][3:0]  qB;
  logic vC, rC, vldC, lastC;
  logic [0:0][7:0]  dC;
  logic [0:0][15:0] qC;

  ser_packer #(.NO_CH(2), .BW_IN(12), .SER_BW(4)) uA (
    .clk(clk), .rst(rst), .vld_in(vA), .rdy_in(rA), .data_in(dA),
    .vld_out(vldA), .data_out(qA), .last_out(lastA));

  ser_packer #(.NO_CH(1), .BW_IN(10), .SER_BW(4)) uB (
    .clk(clk), .rst(rst), .vld_in(vB), .rdy_in(rB), .data_in(dB),
    .vld_out(vldB), .data_out(qB), .last_out(lastB));

  ser_packer #(.NO_CH(1), .BW_IN(8), .SER_BW(16)) uC (
    .clk(clk), .rst(rst), .vld_in(vC), .rdy_in(rC), .data_in(dC),
    .vld_out(vldC), .data_out(qC), .last_out(lastC));

  localparam int NC = 4096;
  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int last_start = -100;
  int busy_until = -100;
  int s_m;
  bit mon = 0;
  bit ev[NC];
  bit el[NC];
  bit [7:0] ed[NC];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit [3:0] chunk(input logic [11:0] w, input int k);
    longint sx;
    sx = longint'($signed(w));
    return 4'((sx >>> (4 * k)) & 15);
  endfunction

  // Each accepted word occupies the 3 cycles after the later of its accept
  // edge and the end of the previous word; rdy is high once all are started.
  always @(posedge clk) begin
    if (rst) begin
      for (int m = cyc + 1; m < NC; m++) begin
        ev[m] = 0;
        el[m] = 0;
      end
      last_start = -100;
      busy_until = -100;
    end else if (vA && last_start <= cyc) begin
      s_m = (busy_until >= cyc + 1) ? busy_until + 1 : cyc + 1;
      for (int k = 0; k < 3; k++) begin
        if (s_m + k < NC) begin
          ev[s_m+k] = 1;
          el[s_m+k] = (k == 2);
          ed[s_m+k] = {chunk(dA[1], k), chunk(dA[0], k)};
        end
      end
      last_start = s_m;
      busy_until = s_m + 2;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (mon) begin
      chk("A_vld_out", vldA, ev[cyc]);
      chk("A_last_out", lastA, el[cyc]);
      chk("A_rdy_in", rA, !rst && last_start <= cyc);
      if (ev[cyc]) chk("A_data_out", qA, ed[cyc]);
    end
  end

  bit deser = 0;
  int kk = 0;
  logic [11:0] wbuf;
  int words[$];

  always @(negedge clk) begin
    if (deser && vldA) begin
      wbuf[4*kk +: 4] = qA[0];
      kk++;
      if (lastA) begin
        words.push_back(int'($signed(wbuf)));
        kk = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendA(input logic [11:0] w0, input logic [11:0] w1,
                       output int at);
    int t;
    bit a;
    vA = 1;
    dA[0] = w0;
    dA[1] = w1;
    t = 0;
    a = 0;
    at = -1;
    while (!a && t < 20) begin
      @(negedge clk);
      a = rA;
      at = cyc;
      tick();
      t++;
    end
    chk("A_accept_bound", a, 1);
  endtask

  bit [3:0] e0[3];
  bit [3:0] e1[3];
  bit [3:0] eb[3];
  int at[4];
  int lb[6];
  int mx;
  int exp_mx[3];

  initial begin
    rst = 1; vA = 0; dA = '0; vB = 0; dB = '0; vC = 0; dC = '0;
    tick();
    tick();
    mon = 1;
    @(negedge clk);
    chk("rst_rdy", rA, 0);
    chk("rst_vldB", vldB, 0);
    tick();
    rst = 0;
    @(negedge clk);
    chk("post_rst_data", qA, 0);
    chk("post_rst_rdy", rA, 1);
    chk("post_rst_lastC", lastC, 0);

    // single word on the 2-channel instance
    e0 = '{4'hC, 4'hB, 4'hA};
    e1 = '{4'h3, 4'h2, 4'h1};
    dA[0] = 12'hABC; dA[1] = 12'h123; vA = 1;
    tick();
    vA = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("single_ch0", qA[0], e0[k]);
      chk("single_ch1", qA[1], e1[k]);
      chk("single_last", lastA, k == 2);
    end
    @(negedge clk);
    chk("single_done", vldA, 0);

    // sign extension with BW_IN=10
    eb = '{4'h5, 4'hA, 4'hE};
    tick();
    dB[0] = 10'h2A5; vB = 1;
    tick();
    vB = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("B_neg", qB[0], eb[k]);
    end
    tick();
    eb = '{4'h5, 4'hA, 4'h0};
    dB[0] = 10'h0A5; vB = 1;
    tick();
    vB = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("B_pos", qB[0], eb[k]);
    end

    // single-chunk words back to back
    tick();
    dC[0] = 8'h80; vC = 1;
    @(negedge clk);
    chk("C_rdy0", rC, 1);
    tick();
    dC[0] = 8'h7F;
    @(negedge clk);
    chk("C_w0", qC, 16'hFF80);
    chk("C_last0", lastC, 1);
    chk("C_rdy1", rC, 1);
    tick();
    vC = 0;
    @(negedge clk);
    chk("C_w1", qC, 16'h007F);
    chk("C_last1", lastC & vldC, 1);
    @(negedge clk);
    chk("C_idle", vldC | lastC, 0);

    // continuous input: accepts at relative cycles 0,1,4,7
    tick();
    sendA(12'h111, 12'h222, at[0]);
    sendA(12'h333, 12'h444, at[1]);
    sendA(12'h555, 12'h666, at[2]);
    sendA(12'h777, 12'h888, at[3]);
    vA = 0;
    chk("cont_acc1", at[1] - at[0], 1);
    chk("cont_acc2", at[2] - at[0], 4);
    chk("cont_acc3", at[3] - at[0], 7);
    repeat (12) tick();

    // reset on chunk 1 with hold full; the held word must vanish
    sendA(12'hDEF, 12'h0AB, at[0]);
    sendA(12'h9C3, 12'h7E1, at[1]);
    vA = 0;
    rst = 1;
    tick();
    @(negedge clk);
    chk("mid_rst_vld", vldA, 0);
    chk("mid_rst_rdy", rA, 0);
    chk("mid_rst_data", qA, 0);
    tick();
    rst = 0;
    sendA(12'h5A5, 12'h0F0, at[2]);
    vA = 0;
    @(negedge clk);
    chk("rst_new_ch0", qA[0], 4'h5);
    chk("rst_new_ch1", qA[1], 4'h0);
    chk("rst_new_last", lastA, 0);
    repeat (8) tick();

    // serial max over consecutive word pairs
    lb = '{-5, 3, 7, 7, -2048, -1};
    exp_mx = '{3, 7, -1};
    kk = 0;
    words.delete();
    deser = 1;
    for (int p = 0; p < 6; p++) sendA(12'(lb[p]), 12'h000, at[0]);
    vA = 0;
    repeat (25) tick();
    deser = 0;
    chk("pool_words", words.size(), 6);
    if (words.size() >= 6) begin
      for (int p = 0; p < 3; p++) begin
        mx = (words[2*p] > words[2*p+1]) ? words[2*p] : words[2*p+1];
        chk("pool_max", mx, exp_mx[p]);
      end
    end

    // randomized traffic with sporadic resets
    repeat (600) begin
      vA = ($urandom_range(0, 9) < 6);
      dA[0] = 12'($urandom);
      dA[1] = 12'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 0;
    vA = 0;
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
